// File: rtl/receive_pixel.sv
// UART receiver that rebuilds RGB444 pixels from a high/low byte pair and
// presents them on a valid/ready output with framing, parity and overflow flags.
module receive_pixel #(
  parameter int CLKS_PER_BIT = 434,
  parameter int BITS_N       = 8,
  parameter int PARITY_TYPE  = 0,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_in,
  output logic [11:0] pixel_out,
  output logic        valid_out,
  input  logic        ready_in,
  output logic        frame_error,
  output logic        parity_error,
  output logic        overflow
);

  localparam int TO_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int C_MAXV  = (TO_CLKS > CLKS_PER_BIT) ? TO_CLKS : CLKS_PER_BIT;
  localparam int CW      = $clog2(C_MAXV + 1);
  localparam int BW      = $clog2(BITS_N + 1);

  localparam logic [CW-1:0] C_HALF  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] C_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_MAX   = CW'(C_MAXV);
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CLKS - 1);
  localparam logic [BW-1:0] B_LAST  = BW'(BITS_N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t            r_state;
  logic              r_sync1, r_sync2, r_prev;
  logic [CW-1:0]     r_clk_cnt;
  logic [BW-1:0]     r_bit_cnt;
  logic [BITS_N-1:0] r_shift;
  logic              r_par;
  logic              r_drop;
  logic              r_byte_vld;
  logic              r_byte_err;
  logic              r_phase_lo;
  logic [3:0]        r_hi;
  logic [CW-1:0]     r_to_cnt;
  logic [7:0]        w_byte;
  logic              w_par_bad;

  assign w_byte    = 8'(r_shift);
  assign w_par_bad = (PARITY_TYPE == 1) ? ~(r_par ^ r_sync2) : (r_par ^ r_sync2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= uart_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Frame FSM; r_byte_vld / r_byte_err are one-cycle strobes to the packer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_clk_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_drop       <= 1'b0;
      r_byte_vld   <= 1'b0;
      r_byte_err   <= 1'b0;
      frame_error  <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      r_byte_vld   <= 1'b0;
      r_byte_err   <= 1'b0;
      frame_error  <= 1'b0;
      parity_error <= 1'b0;
      if (r_clk_cnt != C_MAX) r_clk_cnt <= r_clk_cnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (r_prev && !r_sync2) begin
            r_state   <= S_START;
            r_clk_cnt <= '0;
          end
        end
        S_START: begin
          if (r_clk_cnt == C_HALF) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_par     <= 1'b0;
            r_drop    <= 1'b0;
            r_state   <= r_sync2 ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (r_clk_cnt == C_LAST) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_sync2, r_shift[BITS_N-1:1]};
            r_par     <= r_par ^ r_sync2;
            if (r_bit_cnt == B_LAST)
              r_state <= (PARITY_TYPE != 0) ? S_PARITY : S_STOP;
            else
              r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (r_clk_cnt == C_LAST) begin
            r_clk_cnt <= '0;
            r_state   <= S_STOP;
            if (w_par_bad) begin
              parity_error <= 1'b1;
              r_byte_err   <= 1'b1;
              r_drop       <= 1'b1;
            end
          end
        end
        S_STOP: begin
          if (r_clk_cnt == C_LAST) begin
            r_clk_cnt <= '0;
            if (r_sync2) begin
              r_byte_vld <= ~r_drop;
              r_state    <= S_IDLE;
            end else begin
              frame_error <= 1'b1;
              r_byte_err  <= 1'b1;
              r_state     <= S_WAIT_IDLE;
            end
          end
        end
        S_WAIT_IDLE: begin
          // Parked here so a line held low cannot masquerade as a new start bit.
          if (r_sync2) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Byte pairing, partial-pixel timeout and output handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase_lo <= 1'b0;
      r_hi       <= '0;
      r_to_cnt   <= '0;
      pixel_out  <= '0;
      valid_out  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (valid_out && ready_in) valid_out <= 1'b0;
      if (r_byte_err) begin
        r_phase_lo <= 1'b0;
        r_to_cnt   <= '0;
      end else if (r_byte_vld) begin
        r_to_cnt <= '0;
        if (!r_phase_lo) begin
          r_hi       <= w_byte[3:0];
          r_phase_lo <= 1'b1;
        end else begin
          r_phase_lo <= 1'b0;
          if (!valid_out || ready_in) begin
            pixel_out <= {r_hi, w_byte};
            valid_out <= 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end
      end else if (r_phase_lo) begin
        if (r_to_cnt == TO_LAST) begin
          r_phase_lo <= 1'b0;
          r_to_cnt   <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_receive_pixel.sv
// Bench for receive_pixel: u0 runs without parity, u1 with even parity; both
// use a short bit period so long pixel streams stay within the cycle budget.
module tb_receive_pixel;
  localparam int CPB = 16;
  localparam int TOB = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic line0 = 1'b1, line1 = 1'b1, rdy0 = 1'b1, rdy1 = 1'b1;
  logic [11:0] pix0, pix1;
  logic vld0, vld1, fe0, fe1, pe0, pe1, ov0, ov1;

  always #5 clk = ~clk;

  receive_pixel #(.CLKS_PER_BIT(CPB), .BITS_N(8), .PARITY_TYPE(0), .TIMEOUT_BITS(TOB)) u0 (
    .clk(clk), .rst(rst), .uart_in(line0), .pixel_out(pix0), .valid_out(vld0),
    .ready_in(rdy0), .frame_error(fe0), .parity_error(pe0), .overflow(ov0));

  receive_pixel #(.CLKS_PER_BIT(CPB), .BITS_N(8), .PARITY_TYPE(2), .TIMEOUT_BITS(TOB)) u1 (
    .clk(clk), .rst(rst), .uart_in(line1), .pixel_out(pix1), .valid_out(vld1),
    .ready_in(rdy1), .frame_error(fe1), .parity_error(pe1), .overflow(ov1));

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [11:0] exp;
  } vec_t;

  int checks = 0, errors = 0;
  logic [11:0] q0[$], q1[$];
  int nfe0 = 0, npe0 = 0, nov0 = 0, nfe1 = 0, npe1 = 0, nov1 = 0, nv0 = 0;

  always @(negedge clk) begin
    if (vld0 && rdy0) q0.push_back(pix0);
    if (vld1 && rdy1) q1.push_back(pix1);
    if (vld0) nv0++;
    if (fe0) nfe0++;
    if (pe0) npe0++;
    if (ov0) nov0++;
    if (fe1) nfe1++;
    if (pe1) npe1++;
    if (ov1) nov1++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_line(input int w, input logic v);
    if (w == 0) line0 = v; else line1 = v;
  endtask

  task automatic bit_out(input int w, input logic v);
    set_line(w, v);
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int w, input int nbits);
    set_line(w, 1'b1);
    repeat (nbits * CPB) @(negedge clk);
  endtask

  // u1 always carries an even-parity bit; bad_par flips it, bad_stop drives stop low.
  task automatic send_byte(input int w, input logic [7:0] b, input logic bad_par,
                           input logic bad_stop);
    bit_out(w, 1'b0);
    for (int i = 0; i < 8; i++) bit_out(w, b[i]);
    if (w == 1) bit_out(w, (^b) ^ bad_par);
    bit_out(w, ~bad_stop);
    set_line(w, 1'b1);
  endtask

  task automatic send_pix(input int w, input logic [7:0] hi, input logic [7:0] lo);
    send_byte(w, hi, 1'b0, 1'b0);
    send_byte(w, lo, 1'b0, 1'b0);
  endtask

  task automatic wait_q(input int w, input int n);
    int sz;
    for (int i = 0; i < 4000; i++) begin
      sz = (w == 0) ? q0.size() : q1.size();
      if (sz >= n) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL wait_q%0d: got %0d pixels expected %0d", w, sz, n);
  endtask

  initial begin
    vec_t tbl[8];
    logic [11:0] exp_q[$];
    logic [3:0] mhi;
    logic [7:0] b;
    int base, k, r, ph, epe, efe, ov_base;
    logic lg;

    tbl[0] = '{8'h0F, 8'h00, 12'hF00};
    tbl[1] = '{8'h00, 8'h0F, 12'h00F};
    tbl[2] = '{8'hFF, 8'hFF, 12'hFFF};
    tbl[3] = '{8'hF5, 8'hA3, 12'h5A3};
    tbl[4] = '{8'h00, 8'h00, 12'h000};
    tbl[5] = '{8'h0A, 8'hBC, 12'hABC};
    tbl[6] = '{8'h1C, 8'h3D, 12'hC3D};
    tbl[7] = '{8'h97, 8'h80, 12'h780};

    repeat (3) @(negedge clk);
    chk("rst_pix0", pix0, 0);
    chk("rst_vld0", vld0, 0);
    chk("rst_err0", {fe0, pe0, ov0}, 0);
    chk("rst_vld1", vld1, 0);
    rst = 1'b1;
    idle(0, 2);

    // single pixel, valid for exactly one cycle with ready high
    send_pix(0, 8'h0F, 8'h00);
    idle(0, 2);
    wait_q(0, 1);
    chk("t1_count", q0.size(), 1);
    if (q0.size() >= 1) chk("t1_pix", q0[0], 12'hF00);
    chk("t1_vcycles", nv0, 1);
    chk("t1_errs", nfe0 + npe0 + nov0, 0);

    // table vectors
    for (int i = 0; i < 8; i++) begin
      base = q0.size();
      send_pix(0, tbl[i].hi, tbl[i].lo);
      idle(0, 1);
      wait_q(0, base + 1);
      if (q0.size() > base) chk($sformatf("tbl%0d", i), q0[base], tbl[i].exp);
    end

    // 100 back-to-back alternating pixels
    base = q0.size();
    for (int i = 0; i < 100; i++) begin
      if (i % 2 == 0) send_pix(0, 8'h0F, 8'h00); else send_pix(0, 8'h00, 8'h0F);
    end
    idle(0, 2);
    wait_q(0, base + 100);
    k = 0;
    for (int i = 0; i < 100; i++)
      if (base + i < q0.size() && q0[base + i] != ((i % 2 == 0) ? 12'hF00 : 12'h00F)) k++;
    chk("t2_count", q0.size() - base, 100);
    chk("t2_order_bad", k, 0);
    chk("t2_errs", nfe0 + npe0 + nov0, 0);

    // overflow: second pixel dropped while first is held
    rdy0 = 1'b0;
    base = q0.size();
    ov_base = nov0;
    send_pix(0, 8'h00, 8'h0F);
    send_pix(0, 8'h0F, 8'h00);
    idle(0, 2);
    chk("t3_ovf", nov0 - ov_base, 1);
    chk("t3_hold_pix", pix0, 12'h00F);
    chk("t3_hold_vld", vld0, 1);
    rdy0 = 1'b1;
    repeat (2) @(negedge clk);
    chk("t3_vld_drop", vld0, 0);
    chk("t3_acc_count", q0.size() - base, 1);
    if (q0.size() > base) chk("t3_acc_pix", q0[base], 12'h00F);

    // even parity: bad-parity byte dropped
    send_byte(1, 8'h0F, 1'b1, 1'b0);
    send_pix(1, 8'h0A, 8'hBC);
    idle(1, 2);
    wait_q(1, 1);
    chk("t4_pe", npe1, 1);
    chk("t4_fe", nfe1, 0);
    if (q1.size() >= 1) chk("t4_pix", q1[0], 12'hABC);

    // framing error on high byte, line held low then released
    base = q0.size();
    send_byte(0, 8'h07, 1'b0, 1'b1);
    idle(0, 2);
    send_pix(0, 8'h01, 8'h23);
    idle(0, 2);
    wait_q(0, base + 1);
    chk("t5_fe", nfe0, 1);
    if (q0.size() > base) chk("t5_pix", q0[base], 12'h123);

    // partial pixel timed out by a long gap
    base = q0.size();
    send_byte(0, 8'h05, 1'b0, 1'b0);
    idle(0, 25);
    send_pix(0, 8'h0C, 8'h3D);
    idle(0, 2);
    wait_q(0, base + 1);
    chk("t6_count", q0.size() - base, 1);
    if (q0.size() > base) chk("t6_pix", q0[base], 12'hC3D);

    // gap just under timeout keeps the partial pixel
    base = q0.size();
    send_byte(0, 8'h06, 1'b0, 1'b0);
    idle(0, 5);
    send_byte(0, 8'h7E, 1'b0, 1'b0);
    idle(0, 2);
    wait_q(0, base + 1);
    if (q0.size() > base) chk("t6_short_gap", q0[base], 12'h67E);

    // randomized stream on u1 against a byte-level model
    base = q1.size();
    ph = 0; mhi = '0;
    epe = npe1; efe = nfe1;
    for (int i = 0; i < 40; i++) begin
      b  = 8'($urandom);
      r  = $urandom_range(0, 9);
      lg = ($urandom_range(0, 7) == 0);
      idle(1, lg ? 25 : $urandom_range(0, 2));
      send_byte(1, b, r == 0, r == 1);
      if (r == 1) idle(1, 1);
      if (lg) ph = 0;
      if (r == 0) begin epe++; ph = 0; end
      else if (r == 1) begin efe++; ph = 0; end
      else if (ph == 0) begin mhi = b[3:0]; ph = 1; end
      else begin exp_q.push_back({mhi, b}); ph = 0; end
    end
    idle(1, 3);
    wait_q(1, base + exp_q.size());
    chk("rnd_count", q1.size() - base, exp_q.size());
    k = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < q1.size() && q1[base + i] != exp_q[i]) k++;
    chk("rnd_pix_bad", k, 0);
    chk("rnd_pe", npe1, epe);
    chk("rnd_fe", nfe1, efe);
    chk("rnd_ovf", nov1, 0);

    // async reset mid-byte clears outputs immediately
    rdy0 = 1'b0;
    send_pix(0, 8'h0A, 8'hBC);
    idle(0, 1);
    chk("pre_rst_vld", vld0, 1);
    fork
      send_byte(0, 8'h55, 1'b0, 1'b0);
    join_none
    repeat (4 * CPB) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_pix", pix0, 0);
    chk("rst_mid_vld", vld0, 0);
    chk("rst_mid_err", {fe0, pe0, ov0}, 0);
    repeat (10 * CPB) @(negedge clk);
    rst = 1'b1;
    rdy0 = 1'b1;
    idle(0, 2);
    base = q0.size();
    send_pix(0, 8'h01, 8'h23);
    idle(0, 2);
    wait_q(0, base + 1);
    if (q0.size() > base) chk("post_rst_pix", q0[base], 12'h123);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
